route_wbuf: RTL and testbench

Ping-pong route write-back buffer directly downstream of the per-replica route re-ordering stage. It captures the 8-city-per-beat stream that the re-ordering stage emits after an OR0/OR1/THR move into the idle bank, word by word. On an accept/reject decision it either swaps banks, so the new route becomes current, or discards the candidate. The current bank is read back, one word per cycle, by the upstream route reader that feeds the next move.

---
 rtl/route_wbuf.sv | 120 ++++++++++++
 tb/tb_route_wbuf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_wbuf.sv
// Ping-pong route write-back buffer: fills the idle bank with a candidate route,
// then swaps it in or discards it on commit. The current bank is read one word per cycle.
module route_wbuf #(
  parameter int CITY_NUM = 128,
  parameter int CITY_W   = 7,
  localparam int WORDS   = CITY_NUM / 8,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [8*CITY_W-1:0]   in_data_i,
  input  logic                  commit_i,
  input  logic                  accept_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [8*CITY_W-1:0]   rd_data_o,
  output logic                  rd_bank_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int DW = 8 * CITY_W;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_CMT} state_t;

  state_t          state;
  logic [AW-1:0]   wcnt;
  logic [DW-1:0]   mem [2][WORDS];

  logic            wr_en;
  logic            wr_bank;
  logic [AW-1:0]   wr_addr;

  assign busy_o = (state != IDLE);

  // A start beat arriving together with an accepted commit lands in the bank that
  // becomes the write bank after the swap, i.e. the bank that is current now.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_bank = ~rd_bank_o;
    case (state)
      FILL: begin
        if (in_valid_i) begin
          wr_en   = 1'b1;
          wr_addr = start_i ? '0 : wcnt;
        end
      end
      WAIT_CMT: begin
        if (start_i && in_valid_i) begin
          wr_en   = 1'b1;
          wr_bank = (commit_i && accept_i) ? rd_bank_o : ~rd_bank_o;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= in_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_o <= '0;
    else       rd_data_o <= mem[rd_bank_o][rd_addr_i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      rd_bank_o    <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i || commit_i) err_o <= 1'b1;
          if (start_i) begin
            state <= FILL;
            wcnt  <= '0;
          end
        end
        FILL: begin
          if (commit_i) err_o <= 1'b1;
          if (start_i) begin
            wcnt <= in_valid_i ? AW'(1) : '0;
          end else if (in_valid_i) begin
            if (wcnt == AW'(WORDS - 1)) begin
              frame_done_o <= 1'b1;
              state        <= WAIT_CMT;
              wcnt         <= '0;
            end else begin
              wcnt <= wcnt + AW'(1);
            end
          end
        end
        WAIT_CMT: begin
          if (commit_i && accept_i) rd_bank_o <= ~rd_bank_o;
          if (start_i) begin
            state <= FILL;
            wcnt  <= in_valid_i ? AW'(1) : '0;
          end else if (commit_i) begin
            state <= IDLE;
          end else if (in_valid_i) begin
            err_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_wbuf.sv
// Directed self-checking bench for route_wbuf with hand-derived expected route words.
module tb_route_wbuf;

  localparam int CN    = 128;
  localparam int CW    = 7;
  localparam int WORDS = CN / 8;
  localparam int AW    = 4;
  localparam int DW    = 8 * CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          commit_i = 1'b0;
  logic          accept_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [DW-1:0] rd_data_o;
  logic          rd_bank_o;
  logic          frame_done_o;
  logic          busy_o;
  logic          err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  route_wbuf #(.CITY_NUM(CN), .CITY_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .commit_i     (commit_i),
    .accept_i     (accept_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_bank_o    (rd_bank_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  // pattern 0: 8w+k, 1: 127-(8w+k), 2: (8w+k+37) mod 128
  function automatic logic [DW-1:0] pat(int sel, int w);
    logic [DW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = 8 * w + k;
      if (sel == 1) v = 127 - v;
      if (sel == 2) v = (v + 37) % 128;
      r[k*CW +: CW] = CW'(v);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes(logic [CW-1:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*CW +: CW] = v;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [DW-1:0] d);
    in_valid_i = 1'b1;
    in_data_i  = d;
    cyc();
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic commit(logic acc);
    commit_i = 1'b1;
    accept_i = acc;
    cyc();
    commit_i = 1'b0;
    accept_i = 1'b0;
  endtask

  task automatic rd_chk(string tag, int a, logic [DW-1:0] exp);
    rd_addr_i = AW'(a);
    cyc();
    chk(tag, 64'(rd_data_o), 64'(exp));
  endtask

  task automatic send_frame(int sel);
    for (int w = 0; w < WORDS; w++) begin
      beat(pat(sel, w));
      if (w == WORDS - 2) chk("done_early", 64'(frame_done_o), 64'd0);
    end
    chk("done_pulse", 64'(frame_done_o), 64'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_bank", 64'(rd_bank_o), 64'd0);
    chk("rst_data", 64'(rd_data_o), 64'd0);
    chk("rst_done", 64'(frame_done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    reset = 1'b0;
    cyc();

    // init frame, accepted
    pulse_start();
    chk("fill_busy", 64'(busy_o), 64'd1);
    send_frame(0);
    cyc();
    chk("done_one_cycle", 64'(frame_done_o), 64'd0);
    chk("wait_busy", 64'(busy_o), 64'd1);
    commit(1'b1);
    chk("acc1_bank", 64'(rd_bank_o), 64'd1);
    chk("acc1_idle", 64'(busy_o), 64'd0);
    for (int w = 0; w < WORDS; w++) rd_chk("init_rd", w, pat(0, w));

    // rejected frame
    pulse_start();
    send_frame(1);
    commit(1'b0);
    chk("rej_bank", 64'(rd_bank_o), 64'd1);
    for (int w = 0; w < WORDS; w++) rd_chk("rej_rd", w, pat(0, w));

    // gapped frame; also checks read timing across the swap edge
    pulse_start();
    for (int w = 0; w < WORDS; w++) begin
      beat(pat(2, w));
      chk("gap_done", 64'(frame_done_o), (w == WORDS - 1) ? 64'd1 : 64'd0);
      if (w != WORDS - 1)
        for (int g = 0; g < w % 4; g++) begin
          cyc();
          chk("gap_idle_done", 64'(frame_done_o), 64'd0);
        end
    end
    rd_addr_i = AW'(5);
    commit(1'b1);
    chk("gap_bank", 64'(rd_bank_o), 64'd0);
    chk("swap_edge_old", 64'(rd_data_o), 64'(pat(0, 5)));
    cyc();
    chk("swap_next_new", 64'(rd_data_o), 64'(pat(2, 5)));
    for (int w = 0; w < WORDS; w++) rd_chk("gap_rd", w, pat(2, w));

    // abort mid-frame with a start beat
    pulse_start();
    for (int w = 0; w < 5; w++) beat(pat(1, w));
    start_i = 1'b1;
    beat(lanes(7'h55));
    start_i = 1'b0;
    for (int w = 1; w < WORDS; w++) begin
      beat(pat(1, w));
      chk("abort_done", 64'(frame_done_o), (w == WORDS - 1) ? 64'd1 : 64'd0);
    end
    commit(1'b1);
    chk("abort_bank", 64'(rd_bank_o), 64'd1);
    chk("abort_err", 64'(err_o), 64'd0);
    rd_chk("abort_w0", 0, lanes(7'h55));
    for (int w = 1; w < WORDS; w++) rd_chk("abort_rd", w, pat(1, w));

    // commit + start + beat in the same cycle
    pulse_start();
    send_frame(0);
    commit_i   = 1'b1;
    accept_i   = 1'b1;
    start_i    = 1'b1;
    beat(lanes(7'h2A));
    commit_i   = 1'b0;
    accept_i   = 1'b0;
    start_i    = 1'b0;
    chk("cs_bank", 64'(rd_bank_o), 64'd0);
    chk("cs_busy", 64'(busy_o), 64'd1);
    rd_chk("cs_new_rd", 3, pat(0, 3));
    for (int w = 1; w < WORDS; w++) begin
      beat(pat(2, w));
      chk("cs_done", 64'(frame_done_o), (w == WORDS - 1) ? 64'd1 : 64'd0);
    end
    commit(1'b1);
    chk("cs_bank2", 64'(rd_bank_o), 64'd1);
    rd_chk("cs_w0", 0, lanes(7'h2A));
    for (int w = 1; w < WORDS; w++) rd_chk("cs_rd", w, pat(2, w));
    chk("cs_err", 64'(err_o), 64'd0);

    // protocol errors in IDLE
    beat(lanes(7'h00));
    chk("err_set", 64'(err_o), 64'd1);
    cyc();
    cyc();
    chk("err_sticky", 64'(err_o), 64'd1);
    commit(1'b1);
    chk("err_commit_bank", 64'(rd_bank_o), 64'd1);
    chk("err_idle", 64'(busy_o), 64'd0);
    rd_chk("err_storage", 0, lanes(7'h2A));

    // asynchronous reset mid-fill
    pulse_start();
    for (int w = 0; w < 3; w++) beat(pat(0, w));
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_bank", 64'(rd_bank_o), 64'd0);
    chk("arst_data", 64'(rd_data_o), 64'd0);
    chk("arst_done", 64'(frame_done_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    cyc();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
